// File: rtl/ysyx_23060059_lsu.sv
// Load/store unit between EXU and WBU: one aligned 32-bit bus access per instruction,
// load data shaping, and a registered valid/ready hand-off of the write-back packet.
module ysyx_23060059_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        receive_valid,
   output logic        send_ready,
   input  logic [31:0] result_i,
   input  logic [31:0] rsb_i,
   input  logic        ren_i,
   input  logic        wen_i,
   input  logic [7:0]  wmask_i,
   input  logic [31:0] rmask_i,
   input  logic        m_signed_i,
   input  logic [4:0]  rd_i,
   input  logic        reg_en_i,
   input  logic [31:0] pc_i,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        send_valid,
   input  logic        receive_ready,
   output logic [31:0] wb_data_o,
   output logic [4:0]  rd_o,
   output logic        reg_en_o,
   output logic [31:0] pc_o,
   output logic        err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   logic [7:0]  timer;
   logic [1:0]  addr_lo;
   logic [31:0] result_q;
   logic [31:0] rmask_q;
   logic        ren_q;
   logic        signed_q;
   logic        reg_en_q;

   logic        is_half;
   logic        is_word;
   logic        mem_access;
   logic        bad;
   logic [31:0] shifted;
   logic [31:0] masked;
   logic [31:0] msb_mask;
   logic [31:0] load_data;
   logic        timed_out;

   // Access size comes from the write strobes for stores and from the read mask for loads.
   always_comb begin
      is_half    = wen_i ? (wmask_i == 8'h03) : (rmask_i == 32'h0000FFFF);
      is_word    = wen_i ? (wmask_i == 8'h0F) : (rmask_i == 32'hFFFFFFFF);
      mem_access = ren_i || wen_i;
      bad        = (ren_i && wen_i) ||
                   (mem_access && ((is_half && result_i[0]) || (is_word && (result_i[1:0] != 2'b00))));
   end

   // The top set bit of the contiguous low mask is the sign bit of the loaded value.
   always_comb begin
      shifted   = mem_rdata >> {addr_lo, 3'b000};
      masked    = shifted & rmask_q;
      msb_mask  = rmask_q ^ (rmask_q >> 1);
      load_data = (signed_q && |(masked & msb_mask)) ? (masked | ~rmask_q) : masked;
      timed_out = (timer == 8'(TIMEOUT - 1));
   end

   assign send_ready = (state == IDLE);
   assign busy_o     = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         addr_lo       <= '0;
         result_q      <= '0;
         rmask_q       <= '0;
         ren_q         <= 1'b0;
         signed_q      <= 1'b0;
         reg_en_q      <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wstrb     <= '0;
         send_valid    <= 1'b0;
         wb_data_o     <= '0;
         rd_o          <= '0;
         reg_en_o      <= 1'b0;
         pc_o          <= '0;
         err_o         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (receive_valid) begin
                  timer     <= '0;
                  addr_lo   <= result_i[1:0];
                  result_q  <= result_i;
                  rmask_q   <= rmask_i;
                  ren_q     <= ren_i;
                  signed_q  <= m_signed_i;
                  reg_en_q  <= reg_en_i;
                  rd_o      <= rd_i;
                  pc_o      <= pc_i;
                  mem_addr  <= {result_i[31:2], 2'b00};
                  mem_wen   <= wen_i;
                  mem_wdata <= rsb_i << {result_i[1:0], 3'b000};
                  mem_wstrb <= wmask_i[3:0] << result_i[1:0];
                  if (bad) begin
                     state      <= DONE;
                     send_valid <= 1'b1;
                     err_o      <= 1'b1;
                     wb_data_o  <= '0;
                     reg_en_o   <= 1'b0;
                  end else if (!mem_access) begin
                     state      <= DONE;
                     send_valid <= 1'b1;
                     err_o      <= 1'b0;
                     wb_data_o  <= result_i;
                     reg_en_o   <= reg_en_i;
                  end else begin
                     state         <= REQ;
                     mem_req_valid <= 1'b1;
                     err_o         <= 1'b0;
                  end
               end
            end
            REQ: begin
               if (timed_out) begin
                  state         <= DONE;
                  mem_req_valid <= 1'b0;
                  send_valid    <= 1'b1;
                  err_o         <= 1'b1;
                  wb_data_o     <= '0;
                  reg_en_o      <= 1'b0;
               end else begin
                  timer <= timer + 8'd1;
                  if (mem_req_ready) begin
                     state         <= WAIT;
                     mem_req_valid <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  state      <= DONE;
                  send_valid <= 1'b1;
                  err_o      <= 1'b0;
                  wb_data_o  <= ren_q ? load_data : result_q;
                  reg_en_o   <= ren_q && reg_en_q;
               end else if (timed_out) begin
                  state      <= DONE;
                  send_valid <= 1'b1;
                  err_o      <= 1'b1;
                  wb_data_o  <= '0;
                  reg_en_o   <= 1'b0;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            DONE: begin
               if (receive_ready) begin
                  state      <= IDLE;
                  send_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
